// File: rtl/pwm_capture.sv
// pwm_capture: measures an incoming PWM waveform and reports period, high
// time and integer duty percent once per completed period. A constant-level
// input produces a static report instead after TIMEOUT_CYCLES without edges.
module pwm_capture #(
   parameter int CNT_W          = 32,
   parameter int TIMEOUT_CYCLES = 50_000_000
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             pwm_i,
   output logic             meas_valid_o,
   output logic [CNT_W-1:0] period_o,
   output logic [CNT_W-1:0] high_o,
   output logic [6:0]       duty_percent_o,
   output logic             static_o,
   output logic             static_level_o,
   output logic             overrun_o,
   output logic             busy_o
);

   localparam int DW   = CNT_W + 7;          // dividend width: high*100
   localparam int IT_W = $clog2(DW + 1);

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_FULL = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [DW-1:0]    HUNDRED  = DW'(100);
   localparam logic [IT_W-1:0]  IT_START = IT_W'(DW);
   localparam logic [IT_W-1:0]  IT_ONE   = IT_W'(1);

   typedef enum logic {
      WAIT_FIRST = 1'b0,
      RUN        = 1'b1
   } acq_state_e;

   // input path
   logic             s1_q, s2_q, s3_q;
   logic             rise, fall;

   // run / idle counters
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] high_run_q;
   logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
   logic             timeout;

   // acquisition and divider
   acq_state_e       state_q;
   logic             div_busy_q;
   logic [IT_W-1:0]  div_it_q;
   logic [CNT_W-1:0] div_rem_q;
   logic [CNT_W-1:0] div_den_q;
   logic [CNT_W-1:0] div_high_q;
   logic [DW-1:0]    div_quo_q;

   logic [CNT_W:0]   rem_shift;
   logic             rem_ge;
   logic [CNT_W-1:0] rem_d;
   logic [DW-1:0]    quo_d;
   logic             div_done, div_free, div_load, run_rise;

   // Two-flop synchronizer plus a history flop for edge detection.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         // NOTE: non-blocking so each flop takes the previous stage's old value.
         s1_q <= pwm_i;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign rise = s2_q & ~s3_q;
   assign fall = ~s2_q & s3_q;

   // Next values of the saturating run counter and the idle counter.
   always_comb begin
      // NOTE: defaults first so every path assigns and no latch is inferred.
      cnt_d      = cnt_q;
      idle_cnt_d = idle_cnt_q;
      if (rise) begin
         cnt_d = CNT_ONE;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + CNT_ONE;
      end
      if (rise || fall) begin
         idle_cnt_d = '0;
      end else if (idle_cnt_q != TMO_FULL) begin
         idle_cnt_d = idle_cnt_q + CNT_ONE;
      end
   end

   // Holding idle_cnt at TMO_FULL makes the timeout fire once per idle stretch.
   assign timeout = ~(rise | fall) && (idle_cnt_q == TMO_LAST);

   // Run counter, latched high time and idle counter registers.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         cnt_q      <= '0;
         high_run_q <= '0;
         idle_cnt_q <= '0;
      end else begin
         cnt_q      <= cnt_d;
         idle_cnt_q <= idle_cnt_d;
         if (fall) begin
            high_run_q <= cnt_q;
         end
      end
   end

   // One restoring-division step: shift in the next dividend bit, subtract if it fits.
   always_comb begin
      rem_shift = {div_rem_q, div_quo_q[DW-1]};
      rem_ge    = (rem_shift >= {1'b0, div_den_q});
      rem_d     = rem_ge ? (rem_shift[CNT_W-1:0] - div_den_q) : rem_shift[CNT_W-1:0];
      quo_d     = {div_quo_q[DW-2:0], rem_ge};
   end

   // A divider in its final cycle counts as free so back-to-back periods of
   // exactly CNT_W+8 cycles are still accepted.
   assign div_done = div_busy_q && (div_it_q == '0);
   assign div_free = !div_busy_q || div_done;
   assign run_rise = (state_q == RUN) && rise;
   assign div_load = run_rise && div_free;

   // Acquisition FSM, divider sequencing and registered result outputs.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         // NOTE: the divider datapath is reset too, so aborted work leaves no residue.
         state_q        <= WAIT_FIRST;
         div_busy_q     <= 1'b0;
         div_it_q       <= '0;
         div_rem_q      <= '0;
         div_den_q      <= '0;
         div_high_q     <= '0;
         div_quo_q      <= '0;
         meas_valid_o   <= 1'b0;
         period_o       <= '0;
         high_o         <= '0;
         duty_percent_o <= '0;
         static_o       <= 1'b0;
         static_level_o <= 1'b0;
         overrun_o      <= 1'b0;
      end else begin
         meas_valid_o <= 1'b0;
         if (timeout) begin
            // Static report; any divide in flight is dropped unpublished.
            state_q        <= WAIT_FIRST;
            div_busy_q     <= 1'b0;
            div_it_q       <= '0;
            period_o       <= '0;
            high_o         <= '0;
            duty_percent_o <= s2_q ? 7'd100 : 7'd0;
            static_o       <= 1'b1;
            static_level_o <= s2_q;
            meas_valid_o   <= 1'b1;
         end else begin
            if (rise) begin
               state_q <= RUN;
            end
            if (div_done) begin
               period_o       <= div_den_q;
               high_o         <= div_high_q;
               duty_percent_o <= div_quo_q[6:0];
               static_o       <= 1'b0;
               meas_valid_o   <= 1'b1;
            end
            if (div_load) begin
               div_busy_q <= 1'b1;
               div_it_q   <= IT_START;
               div_rem_q  <= '0;
               div_den_q  <= cnt_q;
               div_high_q <= high_run_q;
               div_quo_q  <= DW'(high_run_q) * HUNDRED;
            end else if (div_done) begin
               div_busy_q <= 1'b0;
            end else if (div_busy_q) begin
               div_it_q  <= div_it_q - IT_ONE;
               div_rem_q <= rem_d;
               div_quo_q <= quo_d;
            end
            if (run_rise && !div_free) begin
               overrun_o <= 1'b1;
            end
         end
      end
   end

   assign busy_o = div_busy_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: drives PWM patterns into pwm_capture and compares every
// report, plus busy/overrun each cycle, against an event-level reference model
// that works from sample times of pwm_i.
module tb_pwm_capture;

   localparam int CNT_W = 32;
   localparam int TMO   = 1000;
   localparam int LAT   = CNT_W + 10;   // closing-rise sample to meas_valid_o

   logic             clk  = 1'b0;
   logic             rstn = 1'b0;
   logic             pwm_i = 1'b0;
   logic             meas_valid_o;
   logic [CNT_W-1:0] period_o;
   logic [CNT_W-1:0] high_o;
   logic [6:0]       duty_percent_o;
   logic             static_o;
   logic             static_level_o;
   logic             overrun_o;
   logic             busy_o;

   pwm_capture #(
      .CNT_W          (CNT_W),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk            (clk),
      .rstn           (rstn),
      .pwm_i          (pwm_i),
      .meas_valid_o   (meas_valid_o),
      .period_o       (period_o),
      .high_o         (high_o),
      .duty_percent_o (duty_percent_o),
      .static_o       (static_o),
      .static_level_o (static_level_o),
      .overrun_o      (overrun_o),
      .busy_o         (busy_o)
   );

   always #5 clk = ~clk;

   // One expected report. load..stop is the divider-busy window; abort != 0
   // means a timeout killed it at that edge and no pulse is due.
   typedef struct {
      int     due;
      int     load;
      int     abort;
      bit     is_static;
      longint period;
      longint high;
      longint duty;
      bit     level;
   } rep_t;

   rep_t exp_q[$];

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // ---------------- reference model (sample-time arithmetic) ----------------
   int   ecnt = 0;        // index of the current clk edge
   bit   m_lvl = 0;       // last sampled input level
   int   m_last_tr = 0;   // edge index of the last input transition
   bit   m_in_run = 0;    // a rise has been seen since reset/timeout
   int   m_rise_n = 0;
   int   m_high = 0;
   int   m_busy_until = 0;
   bit   m_ovr = 0;
   int   m_ovr_edge = 0;
   bit   m_level = 0;     // expected static_level_o
   rep_t m_new;

   always @(posedge clk) begin
      ecnt++;
      if (!rstn) begin
         exp_q.delete();
         m_lvl        = 1'b0;
         m_last_tr    = ecnt - 2;
         m_in_run     = 1'b0;
         m_busy_until = 0;
         m_ovr        = 1'b0;
         m_level      = 1'b0;
      end else if (pwm_i !== m_lvl) begin
         if (pwm_i) begin
            if (m_in_run) begin
               if (ecnt + 2 >= m_busy_until) begin
                  m_new.due       = ecnt + LAT;
                  m_new.load      = ecnt + 2;
                  m_new.abort     = 0;
                  m_new.is_static = 1'b0;
                  m_new.period    = ecnt - m_rise_n;
                  m_new.high      = m_high;
                  m_new.duty      = (longint'(m_high) * 100) / longint'(ecnt - m_rise_n);
                  m_new.level     = 1'b0;
                  exp_q.push_back(m_new);
                  m_busy_until    = m_new.due;
               end else if (!m_ovr) begin
                  m_ovr      = 1'b1;
                  m_ovr_edge = ecnt + 2;
               end
            end
            m_in_run = 1'b1;
            m_rise_n = ecnt;
         end else begin
            m_high = ecnt - m_rise_n;
         end
         m_lvl     = pwm_i;
         m_last_tr = ecnt;
      end else if (ecnt - m_last_tr == TMO) begin
         for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].abort == 0 && exp_q[i].due >= ecnt + 2) begin
               m_new       = exp_q[i];
               m_new.abort = ecnt + 2;
               exp_q[i]    = m_new;
            end
         end
         m_new.due       = ecnt + 2;
         m_new.load      = ecnt + 2;
         m_new.abort     = 0;
         m_new.is_static = 1'b1;
         m_new.period    = 0;
         m_new.high      = 0;
         m_new.duty      = m_lvl ? 100 : 0;
         m_new.level     = m_lvl;
         exp_q.push_back(m_new);
         m_in_run     = 1'b0;
         m_busy_until = 0;
      end
   end

   // ---------------- per-cycle checker ----------------
   bit   c_pulse;
   bit   c_busy;
   rep_t c_hit;

   function automatic int stop_of(input rep_t r);
      return (r.abort != 0) ? r.abort : r.due;
   endfunction

   always @(posedge clk) begin
      #1;
      c_pulse = 1'b0;
      while (exp_q.size() > 0 && stop_of(exp_q[0]) <= ecnt) begin
         if (exp_q[0].abort == 0 && exp_q[0].due == ecnt) begin
            c_pulse = 1'b1;
            c_hit   = exp_q[0];
         end
         void'(exp_q.pop_front());
      end
      c_busy = 1'b0;
      foreach (exp_q[i]) begin
         if (!exp_q[i].is_static && exp_q[i].load <= ecnt && ecnt < stop_of(exp_q[i]))
            c_busy = 1'b1;
      end
      if (c_pulse) begin
         if (c_hit.is_static) m_level = c_hit.level;
         check("meas_valid", meas_valid_o, 1);
         check("period", period_o, c_hit.period);
         check("high", high_o, c_hit.high);
         check("duty", duty_percent_o, c_hit.duty);
         check("static", static_o, c_hit.is_static);
         check("static_level", static_level_o, m_level);
      end else if (meas_valid_o !== 1'b0) begin
         check("unexpected_valid", meas_valid_o, 0);
      end
      check("busy", busy_o, c_busy);
      check("overrun", overrun_o, m_ovr && (ecnt >= m_ovr_edge));
   end

   // ---------------- stimulus ----------------
   task automatic hold(input logic lvl, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         pwm_i = lvl;
      end
   endtask

   task automatic wave(input int period, input int high, input int n);
      for (int i = 0; i < n; i++) begin
         hold(1'b1, high);
         hold(1'b0, period - high);
      end
   endtask

   task automatic check_out(input string tag, input longint per, input longint hi,
                            input longint duty, input bit st);
      @(posedge clk);
      #1;
      check({tag, "_period"}, period_o, per);
      check({tag, "_high"}, high_o, hi);
      check({tag, "_duty"}, duty_percent_o, duty);
      check({tag, "_static"}, static_o, st);
   endtask

   task automatic check_zero(input string tag);
      @(posedge clk);
      #1;
      check({tag, "_valid"}, meas_valid_o, 0);
      check({tag, "_period"}, period_o, 0);
      check({tag, "_high"}, high_o, 0);
      check({tag, "_duty"}, duty_percent_o, 0);
      check({tag, "_static"}, static_o, 0);
      check({tag, "_level"}, static_level_o, 0);
      check({tag, "_overrun"}, overrun_o, 0);
      check({tag, "_busy"}, busy_o, 0);
   endtask

   initial begin
      #(3_000_000);
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int p, h;
      rstn  = 1'b0;
      pwm_i = 1'b0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      @(negedge clk);
      rstn = 1'b1;

      // 50% at period 1000
      wave(1000, 500, 4);
      check_out("w50", 1000, 500, 50, 0);

      // narrow and wide pulses, floor rounding
      wave(300, 1, 3);
      check_out("h1", 300, 1, 0, 0);
      wave(300, 299, 3);
      check_out("h299", 300, 299, 99, 0);

      // static high, then static low, then resume 25%
      hold(1'b1, TMO + 100);
      check_out("st_hi", 0, 0, 100, 1);
      check("st_hi_level", static_level_o, 1);
      hold(1'b0, TMO + 100);
      check_out("st_lo", 0, 0, 0, 1);
      check("st_lo_level", static_level_o, 0);
      wave(400, 100, 3);
      check_out("w25", 400, 100, 25, 0);

      // duty change at a period boundary
      wave(500, 50, 3);
      check_out("w10", 500, 50, 10, 0);
      wave(500, 400, 3);
      check_out("w80", 500, 400, 80, 0);

      // short periods: 2 of 3, then period 20 -> overrun
      wave(3, 2, 60);
      check_out("h2of3", 3, 2, 66, 0);
      wave(20, 10, 20);
      check("overrun_set", overrun_o, 1);
      wave(500, 250, 2);
      check("overrun_sticky", overrun_o, 1);

      // reset in the middle of a divide
      hold(1'b1, 20);
      @(negedge clk);
      rstn = 1'b0;
      check_zero("mid_rst");
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
      hold(1'b1, 226);
      hold(1'b0, 250);
      wave(500, 250, 3);
      check_out("after_rst", 500, 250, 50, 0);

      // randomized periods, occasionally too short to avoid overrun
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 7) == 0) p = $urandom_range(4, 39);
         else                           p = $urandom_range(41, 700);
         h = $urandom_range(1, p - 1);
         wave(p, h, $urandom_range(1, 3));
      end
      hold(1'b0, TMO + 100);
      check_out("final_static", 0, 0, 0, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
